// File: rtl/dut_host_if.sv
// Bus bundle between the command/response side and the dut method side.
// The host connects through slave; the driving environment through master.
interface dut_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_address;
  logic       cmd_data;

  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;

  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic       rsp_err;
  logic       rsp_data;

  modport slave (
    input  cmd_valid, cmd_write, cmd_address, cmd_data,
    input  write_rdy, read_data, read_rdy, rsp_ready,
    output cmd_ready, write_address, write_data, write_en,
    output read_address, read_en,
    output rsp_valid, rsp_write, rsp_err, rsp_data
  );

  modport master (
    output cmd_valid, cmd_write, cmd_address, cmd_data,
    output write_rdy, read_data, read_rdy, rsp_ready,
    input  cmd_ready, write_address, write_data, write_en,
    input  read_address, read_en,
    input  rsp_valid, rsp_write, rsp_err, rsp_data
  );
endinterface

// File: rtl/dut_host.sv
// Single-outstanding command host: forwards one read or write to the dut
// methods, waits for rdy with a bounded timer, and returns one response.
module dut_host #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  dut_host_if.slave   bus,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    RSP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] timer;
  logic [7:0] timer_nx;
  logic       lat_write;
  logic [2:0] lat_addr;
  logic       lat_data;

  logic accept;
  logic wr_fire;
  logic rd_fire;
  logic fire;
  logic tmo;
  logic waiting;
  logic rsp_hs;
  logic busy;

  logic rsp_write_q;
  logic rsp_err_q;
  logic rsp_data_q;

  // Enables are gated by reset too, so rdy inputs can never leak through.
  assign busy    = (state != IDLE);
  assign wr_fire = (state == WR_WAIT) && bus.write_rdy && !RST_N;
  assign rd_fire = (state == RD_WAIT) && bus.read_rdy && !RST_N;
  assign fire    = wr_fire || rd_fire;
  assign waiting = (state == WR_WAIT) || (state == RD_WAIT);
  assign tmo     = waiting && !fire && (timer == TMO_LAST);

  assign bus.cmd_ready     = (state == IDLE) && !RST_N;
  assign bus.write_en      = wr_fire;
  assign bus.read_en       = rd_fire;
  assign bus.write_address = busy ? lat_addr : 3'd0;
  assign bus.write_data    = busy ? lat_data : 1'b0;
  assign bus.read_address  = busy ? lat_addr : 3'd0;
  assign bus.rsp_valid     = (state == RSP) && !RST_N;
  assign bus.rsp_write     = rsp_write_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_data      = rsp_data_q;

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign rsp_hs = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = bus.cmd_write ? WR_WAIT : RD_WAIT;
          timer_nx = 8'd0;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (fire || tmo) state_nx = RSP;
        else             timer_nx = timer + 8'd1;
      end
      RSP: begin
        if (rsp_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      state       <= IDLE;
      timer       <= 8'd0;
      lat_write   <= 1'b0;
      lat_addr    <= 3'd0;
      lat_data    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 1'b0;
      txn_count   <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      if (accept) begin
        lat_write <= bus.cmd_write;
        lat_addr  <= bus.cmd_address;
        lat_data  <= bus.cmd_data;
      end
      if (fire || tmo) begin
        rsp_write_q <= lat_write;
        rsp_err_q   <= tmo;
        rsp_data_q  <= rd_fire ? bus.read_data : 1'b0;
      end
      if (fire) txn_count <= txn_count + 16'd1;
      if (tmo && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dut_host.sv
// Directed scoreboard bench for dut_host: stimulus pushes expected
// {write, err, data} responses, a monitor pops them on each handshake.
module tb_dut_host;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  dut_host_if bus();

  dut_host #(.TIMEOUT(16)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Response monitor: compares every handshake against the scoreboard.
  always @(negedge CLK) begin
    if (!RST_N && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %b expected none at %0t",
                 {bus.rsp_write, bus.rsp_err, bus.rsp_data}, $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("rsp", 32'({bus.rsp_write, bus.rsp_err, bus.rsp_data}), 32'(e));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic w, input logic [2:0] a, input logic d);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = w;
    bus.cmd_address = a;
    bus.cmd_data    = d;
    @(negedge CLK);
    chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (n < max) begin
      @(negedge CLK);
      if (bus.rsp_valid && bus.rsp_ready) break;
      n++;
    end
    if (n == max) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got no rsp_valid expected one within %0d", max);
    end
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = 3'd0;
    bus.cmd_data    = 1'b0;
    bus.write_rdy   = 1'b0;
    bus.read_rdy    = 1'b0;
    bus.read_data   = 1'b0;
    bus.rsp_ready   = 1'b1;

    // reset state, rdy held high must not leak
    repeat (2) step();
    bus.write_rdy = 1'b1;
    bus.read_rdy  = 1'b1;
    @(negedge CLK);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_write_en", 32'(bus.write_en), 32'd0);
    chk("rst_read_en", 32'(bus.read_en), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    step();
    RST_N = 1'b0;
    bus.read_rdy = 1'b0;
    @(negedge CLK);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("idle_wr_addr", 32'(bus.write_address), 32'd0);
    step();

    // write, rdy high: fire N+1, rsp N+2
    exp_q.push_back(3'b100);
    send(1'b1, 3'd3, 1'b1);
    @(negedge CLK);
    chk("wr_en", 32'(bus.write_en), 32'd1);
    chk("wr_addr", 32'(bus.write_address), 32'd3);
    chk("wr_data", 32'(bus.write_data), 32'd1);
    step();
    @(negedge CLK);
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wr_en_once", 32'(bus.write_en), 32'd0);
    step();
    @(negedge CLK);
    chk("wr_txn", 32'(txn_count), 32'd1);
    chk("wr_back_idle", 32'(bus.cmd_ready), 32'd1);
    step();

    // read, rdy low 4 cycles then high
    bus.write_rdy = 1'b0;
    bus.read_data = 1'b1;
    exp_q.push_back(3'b001);
    send(1'b0, 3'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rd_wait_en", 32'(bus.read_en), 32'd0);
      chk("rd_addr", 32'(bus.read_address), 32'd5);
      step();
    end
    bus.read_rdy = 1'b1;
    @(negedge CLK);
    chk("rd_en", 32'(bus.read_en), 32'd1);
    step();
    bus.read_data = 1'b0;
    @(negedge CLK);
    chk("rd_en_once", 32'(bus.read_en), 32'd0);
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    step();
    bus.read_rdy = 1'b0;
    @(negedge CLK);
    chk("rd_txn", 32'(txn_count), 32'd2);
    step();

    // timeout: 16 wait cycles, rsp at N+17
    exp_q.push_back(3'b110);
    send(1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk("tmo_no_en", 32'(bus.write_en), 32'd0);
      step();
    end
    @(negedge CLK);
    chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    step();
    @(negedge CLK);
    chk("tmo_err_count", 32'(err_count), 32'd1);
    chk("tmo_txn", 32'(txn_count), 32'd2);
    step();

    // next command after timeout completes normally
    bus.write_rdy = 1'b1;
    exp_q.push_back(3'b100);
    send(1'b1, 3'd7, 1'b0);
    @(negedge CLK);
    chk("post_tmo_wr_en", 32'(bus.write_en), 32'd1);
    chk("post_tmo_addr", 32'(bus.write_address), 32'd7);
    step();
    wait_done(1);
    bus.write_rdy = 1'b0;

    // boundary: rdy rises in the 16th wait cycle
    bus.read_data = 1'b1;
    exp_q.push_back(3'b001);
    send(1'b0, 3'd6, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      chk("bnd_wait_en", 32'(bus.read_en), 32'd0);
      step();
    end
    bus.read_rdy = 1'b1;
    @(negedge CLK);
    chk("bnd_rd_en", 32'(bus.read_en), 32'd1);
    step();
    bus.read_rdy = 1'b0;
    bus.read_data = 1'b0;
    @(negedge CLK);
    chk("bnd_rsp_err", 32'(bus.rsp_err), 32'd0);
    step();
    @(negedge CLK);
    chk("bnd_err_count", 32'(err_count), 32'd1);
    chk("bnd_txn", 32'(txn_count), 32'd4);
    step();

    // backpressure: rsp held 10 cycles, new cmd ignored
    bus.rsp_ready = 1'b0;
    bus.write_rdy = 1'b1;
    exp_q.push_back(3'b100);
    send(1'b1, 3'd4, 1'b1);
    step();
    bus.write_rdy   = 1'b0;
    bus.read_rdy    = 1'b1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = 3'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("bp_rsp", 32'({bus.rsp_valid, bus.rsp_write, bus.rsp_err,
                         bus.rsp_data}), 32'b1100);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_no_en", 32'({bus.read_en, bus.write_en}), 32'd0);
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_done(1);
    @(negedge CLK);
    chk("bp_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    chk("bp_no_extra", 32'({bus.rsp_valid, bus.read_en}), 32'd0);
    chk("bp_txn", 32'(txn_count), 32'd5);
    step();

    // reset in the middle of RD_WAIT
    bus.read_rdy = 1'b0;
    send(1'b0, 3'd1, 1'b0);
    repeat (3) step();
    bus.read_rdy = 1'b1;
    RST_N = 1'b1;
    #1;
    chk("mid_rst_rd_en", 32'(bus.read_en), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("mid_rst_counts", 32'({txn_count, err_count}), 32'd0);
    repeat (2) step();
    RST_N = 1'b0;
    bus.read_rdy = 1'b0;
    @(negedge CLK);
    chk("post_rst_idle", 32'(bus.cmd_ready), 32'd1);
    chk("post_rst_rd_addr", 32'(bus.read_address), 32'd0);
    step();
    bus.write_rdy = 1'b1;
    exp_q.push_back(3'b100);
    send(1'b1, 3'd3, 1'b1);
    step();
    wait_done(1);
    @(negedge CLK);
    chk("post_rst_txn", 32'(txn_count), 32'd1);
    step();

    // 256 forced timeouts saturate err_count
    bus.write_rdy = 1'b0;
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(3'b010);
      send(1'b0, 3'(k), 1'b0);
      wait_done(40);
      if (k == 253) chk("err_count_254", 32'(err_count), 32'hFE);
    end
    @(negedge CLK);
    chk("err_count_sat", 32'(err_count), 32'hFF);
    chk("sat_txn", 32'(txn_count), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
